// File: rtl/exec_unit_pkg.sv
// Shared opcode and FSM definitions for the execute-stage integer unit.
package alu_defs;

   typedef enum logic [4:0] {
      ALU_ADD   = 5'd0,
      ALU_SUB   = 5'd1,
      ALU_SLL   = 5'd2,
      ALU_SRA   = 5'd3,
      ALU_SRL   = 5'd4,
      ALU_OR    = 5'd5,
      ALU_XOR   = 5'd6,
      ALU_SLT   = 5'd7,
      ALU_SLTU  = 5'd8,
      ALU_AND   = 5'd9,
      ALU_MUL   = 5'd10,
      ALU_MULH  = 5'd11,
      ALU_MULHU = 5'd12,
      ALU_DIV   = 5'd13,
      ALU_DIVU  = 5'd14,
      ALU_REM   = 5'd15,
      ALU_REMU  = 5'd16
   } alu_op_e;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_MUL  = 2'd1,
      ST_DIV  = 2'd2,
      ST_FIX  = 2'd3
   } eu_state_e;

   function automatic logic is_muldiv(alu_op_e op);
      return (op >= ALU_MUL) && (op <= ALU_REMU);
   endfunction

endpackage

// File: rtl/exec_unit_muldiv.sv
// Iterative unsigned shift-add multiplier / restoring divider, one step per cycle.
module iter_muldiv #(
   parameter int WIDTH = 32
) (
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic                 start,
   input  logic                 is_div,
   input  logic [WIDTH-1:0]     opa,
   input  logic [WIDTH-1:0]     opb,
   output logic                 done,
   output logic [2*WIDTH-1:0]   prod,
   output logic [WIDTH-1:0]     quot,
   output logic [WIDTH-1:0]     rem
);

   localparam int CNT_W = $clog2(WIDTH);

   logic [2*WIDTH-1:0] acc_q;
   logic [2*WIDTH-1:0] acc_step;
   logic [WIDTH-1:0]   opb_q;
   logic [WIDTH-1:0]   addend;
   logic [WIDTH:0]     add_sum;
   logic [WIDTH:0]     trial;
   logic [CNT_W-1:0]   cnt_q;
   logic               run_q;
   logic               div_q;

   // Multiply keeps {partial product, multiplier} and shifts right;
   // divide keeps {remainder, dividend/quotient} and shifts left.
   always_comb begin
      addend   = acc_q[0] ? opb_q : {WIDTH{1'b0}};
      add_sum  = {1'b0, acc_q[2*WIDTH-1:WIDTH]} + {1'b0, addend};
      trial    = acc_q[2*WIDTH-1:WIDTH-1] - {1'b0, opb_q};
      acc_step = {add_sum, acc_q[WIDTH-1:1]};
      if (div_q) begin
         if (!trial[WIDTH]) begin
            acc_step = {trial[WIDTH-1:0], acc_q[WIDTH-2:0], 1'b1};
         end else begin
            acc_step = {acc_q[2*WIDTH-2:0], 1'b0};
         end
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         acc_q <= '0;
         opb_q <= '0;
         cnt_q <= '0;
         run_q <= 1'b0;
         div_q <= 1'b0;
      end else if (start) begin
         acc_q <= {{WIDTH{1'b0}}, opa};
         opb_q <= opb;
         cnt_q <= '0;
         run_q <= 1'b1;
         div_q <= is_div;
      end else if (run_q) begin
         acc_q <= acc_step;
         cnt_q <= cnt_q + 1'b1;
         if (done) begin
            run_q <= 1'b0;
         end
      end
   end

   assign done = run_q && (cnt_q == CNT_W'(WIDTH - 1));
   assign prod = acc_q;
   assign quot = acc_q[WIDTH-1:0];
   assign rem  = acc_q[2*WIDTH-1:WIDTH];

endmodule

// File: rtl/exec_unit.sv
// Execute-stage integer unit: registered single-cycle base ALU plus iterative
// RV32M-class multiply/divide behind a valid/ready interface.
module exec_unit
   import alu_defs::*;
#(
   parameter int WIDTH   = 32,
   parameter int SHAMT_W = $clog2(WIDTH)
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [4:0]       op,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] result,
   output logic             busy
);

   localparam logic [WIDTH-1:0] MOST_NEG = {1'b1, {(WIDTH-1){1'b0}}};

   eu_state_e          state_q, state_d;
   alu_op_e            op_e, op_q;
   logic               accept, md_start, md_is_div, md_done, load_base, load_fix;
   logic               sgn_op, a_neg, b_neg;
   logic               neg_q, bzero_q, ovf_q;
   logic [WIDTH-1:0]   mag_a, mag_b, a_q;
   logic [WIDTH-1:0]   alu_res, fix_res;
   logic [WIDTH-1:0]   md_quot, md_rem, quot_fix, rem_fix;
   logic [2*WIDTH-1:0] md_prod, prod_fix;

   assign op_e = alu_op_e'(op);

   // Handshake: a transfer happens on any edge where valid && ready. Input side
   // accepts only in IDLE with the output register free or draining this edge;
   // output side holds result/out_valid stable until out_ready.
   assign in_ready  = (state_q == ST_IDLE) && (!out_valid || out_ready);
   assign accept    = in_valid && in_ready;
   assign md_start  = accept && is_muldiv(op_e);
   assign load_base = accept && !is_muldiv(op_e);
   assign load_fix  = (state_q == ST_FIX) && (!out_valid || out_ready);
   assign busy      = (state_q != ST_IDLE);
   assign md_is_div = op_e inside {ALU_DIV, ALU_DIVU, ALU_REM, ALU_REMU};

   always_comb begin
      alu_res = '0;
      case (op_e)
         ALU_ADD:  alu_res = a + b;
         ALU_SUB:  alu_res = a - b;
         ALU_SLL:  alu_res = a << b[SHAMT_W-1:0];
         ALU_SRA:  alu_res = $signed(a) >>> b[SHAMT_W-1:0];
         ALU_SRL:  alu_res = a >> b[SHAMT_W-1:0];
         ALU_OR:   alu_res = a | b;
         ALU_XOR:  alu_res = a ^ b;
         ALU_SLT:  alu_res = {{(WIDTH-1){1'b0}}, ($signed(a) < $signed(b))};
         ALU_SLTU: alu_res = {{(WIDTH-1){1'b0}}, (a < b)};
         ALU_AND:  alu_res = a & b;
         default:  alu_res = '0;
      endcase
   end

   // The iterative datapath is unsigned; signed ops hand it magnitudes.
   always_comb begin
      sgn_op = op_e inside {ALU_MULH, ALU_DIV, ALU_REM};
      a_neg  = sgn_op && a[WIDTH-1];
      b_neg  = sgn_op && b[WIDTH-1];
      mag_a  = a_neg ? -a : a;
      mag_b  = b_neg ? -b : b;
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         op_q    <= ALU_ADD;
         a_q     <= '0;
         neg_q   <= 1'b0;
         bzero_q <= 1'b0;
         ovf_q   <= 1'b0;
      end else if (md_start) begin
         op_q    <= op_e;
         a_q     <= a;
         neg_q   <= (op_e == ALU_REM) ? a_neg : (a_neg ^ b_neg);
         bzero_q <= (b == '0);
         ovf_q   <= (a == MOST_NEG) && (b == '1);
      end
   end

   iter_muldiv #(.WIDTH(WIDTH)) u_muldiv (
      .clk    (clk),
      .rst_n  (rst_n),
      .start  (md_start),
      .is_div (md_is_div),
      .opa    (mag_a),
      .opb    (mag_b),
      .done   (md_done),
      .prod   (md_prod),
      .quot   (md_quot),
      .rem    (md_rem)
   );

   always_comb begin
      prod_fix = neg_q ? -md_prod : md_prod;
      quot_fix = neg_q ? -md_quot : md_quot;
      rem_fix  = neg_q ? -md_rem  : md_rem;
      fix_res  = '0;
      case (op_q)
         ALU_MUL:   fix_res = md_prod[WIDTH-1:0];
         ALU_MULH:  fix_res = prod_fix[2*WIDTH-1:WIDTH];
         ALU_MULHU: fix_res = md_prod[2*WIDTH-1:WIDTH];
         ALU_DIV:   fix_res = bzero_q ? '1  : (ovf_q ? a_q : quot_fix);
         ALU_DIVU:  fix_res = bzero_q ? '1  : md_quot;
         ALU_REM:   fix_res = bzero_q ? a_q : (ovf_q ? '0 : rem_fix);
         ALU_REMU:  fix_res = bzero_q ? a_q : md_rem;
         default:   fix_res = '0;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q <= ST_IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         ST_IDLE: if (md_start) state_d = md_is_div ? ST_DIV : ST_MUL;
         ST_MUL,
         ST_DIV:  if (md_done) state_d = ST_FIX;
         ST_FIX:  if (load_fix) state_d = ST_IDLE;
         default: state_d = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         out_valid <= 1'b0;
         result    <= '0;
      end else if (load_base) begin
         out_valid <= 1'b1;
         result    <= alu_res;
      end else if (load_fix) begin
         out_valid <= 1'b1;
         result    <= fix_res;
      end else if (out_ready) begin
         out_valid <= 1'b0;
      end
   end

endmodule

// File: tb/tb_exec_unit.sv
// Bench for exec_unit: directed vector table, multi-cycle corner sequences,
// and randomized traffic checked against an arithmetic reference model.
module tb_exec_unit;
   import alu_defs::*;

   localparam int WIDTH = 32;

   logic             clk = 1'b0;
   logic             rst_n = 1'b0;
   logic             in_valid = 1'b0;
   logic             in_ready;
   logic [4:0]       op = '0;
   logic [WIDTH-1:0] a = '0;
   logic [WIDTH-1:0] b = '0;
   logic             out_valid;
   logic             out_ready = 1'b1;
   logic [WIDTH-1:0] result;
   logic             busy;

   int n_checks = 0;
   int n_fail   = 0;
   int xfer_cnt = 0;
   logic [WIDTH-1:0] exp_q[$];

   typedef struct {
      logic [4:0]  op;
      logic [31:0] a;
      logic [31:0] b;
      logic [31:0] exp;
      int          lat;
   } vec_t;

   vec_t vecs[24];

   exec_unit #(.WIDTH(WIDTH)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .op        (op),
      .a         (a),
      .b         (b),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .result    (result),
      .busy      (busy)
   );

   // ---------------- clock / watchdog ----------------
   always #5 clk = ~clk;

   initial begin
      #400000;
      $display("FAIL watchdog: simulation time limit reached, expected test completion");
      $fatal(1, "watchdog expired");
   end

   // ---------------- checking helpers ----------------
   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   task automatic fail_now(input string name);
      n_checks++;
      n_fail++;
      $display("FAIL %s: got timeout expected handshake", name);
   endtask

   // Reference model written straight from the arithmetic definitions.
   function automatic logic [31:0] ref_model(input logic [4:0] opc, input logic [31:0] x, input logic [31:0] y);
      longint          sx, sy, sp;
      longint unsigned ux, uy, up;
      logic [63:0]     p;
      sx = longint'($signed(x));
      sy = longint'($signed(y));
      ux = 64'(x);
      uy = 64'(y);
      case (opc)
         5'd0:  return x + y;
         5'd1:  return x - y;
         5'd2:  return x << y[4:0];
         5'd3:  begin sp = sx >>> y[4:0]; return sp[31:0]; end
         5'd4:  return x >> y[4:0];
         5'd5:  return x | y;
         5'd6:  return x ^ y;
         5'd7:  return (sx < sy) ? 32'd1 : 32'd0;
         5'd8:  return (ux < uy) ? 32'd1 : 32'd0;
         5'd9:  return x & y;
         5'd10: begin up = ux * uy; p = up; return p[31:0]; end
         5'd11: begin sp = sx * sy; p = sp; return p[63:32]; end
         5'd12: begin up = ux * uy; p = up; return p[63:32]; end
         5'd13: begin
            if (y == 32'd0) return 32'hFFFF_FFFF;
            if (x == 32'h8000_0000 && y == 32'hFFFF_FFFF) return x;
            sp = sx / sy;
            return sp[31:0];
         end
         5'd14: return (y == 32'd0) ? 32'hFFFF_FFFF : x / y;
         5'd15: begin
            if (y == 32'd0) return x;
            if (x == 32'h8000_0000 && y == 32'hFFFF_FFFF) return 32'd0;
            sp = sx % sy;
            return sp[31:0];
         end
         5'd16: return (y == 32'd0) ? x : x % y;
         default: return 32'd0;
      endcase
   endfunction

   // ---------------- scoreboard ----------------
   always @(negedge clk) begin
      if (!rst_n) begin
         exp_q.delete();
      end else begin
         if (out_valid && out_ready) begin
            if (exp_q.size() == 0) begin
               n_checks++;
               n_fail++;
               $display("FAIL scoreboard: got unexpected result %h expected no transfer", result);
            end else begin
               check("scoreboard", result, exp_q.pop_front());
            end
            xfer_cnt++;
         end
         if (in_valid && in_ready) exp_q.push_back(ref_model(op, a, b));
      end
   end

   // ---------------- driver tasks ----------------
   task automatic run_vec(input int idx, input vec_t v);
      int waitc;
      int lat;
      int busy_drop;
      out_ready = 1'b1;
      op        = v.op;
      a         = v.a;
      b         = v.b;
      in_valid  = 1'b1;
      waitc = 0;
      while (!in_ready && waitc < 100) begin
         @(posedge clk); #1;
         waitc++;
      end
      if (!in_ready) begin
         in_valid = 1'b0;
         fail_now($sformatf("vec%0d_accept", idx));
         return;
      end
      @(posedge clk); #1;
      in_valid = 1'b0;
      a  = $urandom;
      b  = $urandom;
      op = 5'($urandom_range(0, 31));
      lat = 1;
      busy_drop = 0;
      while (!out_valid && lat < 100) begin
         if (!busy) busy_drop++;
         @(posedge clk); #1;
         lat++;
      end
      check($sformatf("vec%0d_result", idx), result, v.exp);
      check($sformatf("vec%0d_latency", idx), 32'(lat), 32'(v.lat));
      check($sformatf("vec%0d_busy_during", idx), 32'(busy_drop), 32'd0);
      check($sformatf("vec%0d_busy_after", idx), {31'd0, busy}, 32'd0);
      @(posedge clk); #1;
   endtask

   function automatic logic [31:0] pick_operand();
      case ($urandom_range(0, 5))
         0:       return 32'd0;
         1:       return 32'hFFFF_FFFF;
         2:       return 32'h8000_0000;
         3:       return 32'($urandom_range(0, 10));
         default: return $urandom;
      endcase
   endfunction

   // ---------------- test sequence ----------------
   initial begin
      int x0, low, other_low, waitc;

      vecs[0]  = '{ALU_ADD,   32'hFFFF_FFFF, 32'h0000_0001, 32'h0000_0000, 1};
      vecs[1]  = '{ALU_SRA,   32'h8000_0000, 32'h0000_0021, 32'hC000_0000, 1};
      vecs[2]  = '{ALU_SUB,   32'h0000_0005, 32'h0000_0007, 32'hFFFF_FFFE, 1};
      vecs[3]  = '{ALU_SLL,   32'h0000_0001, 32'h0000_0024, 32'h0000_0010, 1};
      vecs[4]  = '{ALU_SRL,   32'h8000_0000, 32'h0000_003F, 32'h0000_0001, 1};
      vecs[5]  = '{ALU_SLT,   32'hFFFF_FFFF, 32'h0000_0001, 32'h0000_0001, 1};
      vecs[6]  = '{ALU_SLTU,  32'hFFFF_FFFF, 32'h0000_0001, 32'h0000_0000, 1};
      vecs[7]  = '{ALU_OR,    32'h0000_00F0, 32'h0000_000F, 32'h0000_00FF, 1};
      vecs[8]  = '{ALU_XOR,   32'h0000_00FF, 32'h0000_000F, 32'h0000_00F0, 1};
      vecs[9]  = '{ALU_AND,   32'h0000_00FF, 32'h0000_000F, 32'h0000_000F, 1};
      vecs[10] = '{5'd20,     32'h0000_0005, 32'h0000_0005, 32'h0000_0000, 1};
      vecs[11] = '{ALU_MUL,   32'hFFFF_FFFE, 32'h0000_0003, 32'hFFFF_FFFA, 34};
      vecs[12] = '{ALU_MULH,  32'hFFFF_FFFE, 32'h0000_0003, 32'hFFFF_FFFF, 34};
      vecs[13] = '{ALU_MULHU, 32'hFFFF_FFFE, 32'h0000_0003, 32'h0000_0002, 34};
      vecs[14] = '{ALU_DIV,   32'hFFFF_FFF9, 32'h0000_0002, 32'hFFFF_FFFD, 34};
      vecs[15] = '{ALU_REM,   32'hFFFF_FFF9, 32'h0000_0002, 32'hFFFF_FFFF, 34};
      vecs[16] = '{ALU_DIVU,  32'h0000_0005, 32'h0000_0000, 32'hFFFF_FFFF, 34};
      vecs[17] = '{ALU_REMU,  32'h0000_0005, 32'h0000_0000, 32'h0000_0005, 34};
      vecs[18] = '{ALU_DIV,   32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 34};
      vecs[19] = '{ALU_REM,   32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_0000, 34};
      vecs[20] = '{ALU_DIV,   32'hFFFF_FFF7, 32'h0000_0000, 32'hFFFF_FFFF, 34};
      vecs[21] = '{ALU_REM,   32'hFFFF_FFF7, 32'h0000_0000, 32'hFFFF_FFF7, 34};
      vecs[22] = '{ALU_DIVU,  32'hFFFF_FFFF, 32'h0000_0010, 32'h0FFF_FFFF, 34};
      vecs[23] = '{ALU_REMU,  32'hFFFF_FFFF, 32'h0000_0010, 32'h0000_000F, 34};

      // reset
      rst_n = 1'b0;
      repeat (3) @(posedge clk);
      #1 rst_n = 1'b1;
      check("reset_out_valid", {31'd0, out_valid}, 32'd0);
      check("reset_result",    result, 32'd0);
      check("reset_busy",      {31'd0, busy}, 32'd0);
      check("reset_in_ready",  {31'd0, in_ready}, 32'd1);

      // directed vector table
      for (int i = 0; i < 24; i++) run_vec(i, vecs[i]);

      // backpressure at MUL completion
      out_ready = 1'b0;
      op = ALU_MUL; a = 32'hFFFF_FFFE; b = 32'd3; in_valid = 1'b1;
      @(posedge clk); #1;
      in_valid = 1'b0;
      waitc = 0;
      while (!out_valid && waitc < 100) begin
         @(posedge clk); #1;
         waitc++;
      end
      check("bp_result", result, 32'hFFFF_FFFA);
      for (int i = 0; i < 5; i++) begin
         @(posedge clk); #1;
         check($sformatf("bp_hold%0d_valid", i), {31'd0, out_valid}, 32'd1);
         check($sformatf("bp_hold%0d_result", i), result, 32'hFFFF_FFFA);
         check($sformatf("bp_hold%0d_in_ready", i), {31'd0, in_ready}, 32'd0);
      end
      x0 = xfer_cnt;
      out_ready = 1'b1;
      @(posedge clk); #1;
      check("bp_drained_valid", {31'd0, out_valid}, 32'd0);
      check("bp_one_transfer", 32'(xfer_cnt - x0), 32'd1);

      // stream of 8 ADDs, one result per cycle
      x0 = xfer_cnt;
      for (int i = 0; i < 8; i++) begin
         op = ALU_ADD; a = 32'(i * 3); b = 32'd100; in_valid = 1'b1;
         check($sformatf("stream%0d_in_ready", i), {31'd0, in_ready}, 32'd1);
         @(posedge clk); #1;
         check($sformatf("stream%0d_out_valid", i), {31'd0, out_valid}, 32'd1);
      end
      in_valid = 1'b0;
      @(posedge clk); #1;
      check("stream_transfers", 32'(xfer_cnt - x0), 32'd8);

      // DIV issued mid-stream stalls the next ADD until its result is taken
      other_low = 0;
      for (int k = 0; k < 7; k++) begin
         if (k == 3) begin
            op = ALU_DIV; a = 32'd100; b = 32'd7;
         end else begin
            op = ALU_ADD; a = 32'(k); b = 32'(k * 11);
         end
         in_valid = 1'b1;
         low = 0;
         while (!in_ready && low < 100) begin
            @(posedge clk); #1;
            low++;
         end
         if (k == 4) check("midstream_div_stall", 32'(low), 32'(WIDTH + 1));
         else other_low += low;
         @(posedge clk); #1;
      end
      in_valid = 1'b0;
      check("midstream_other_stalls", 32'(other_low), 32'd0);
      @(posedge clk); #1;

      // reset during iteration 10 of a DIVU
      op = ALU_DIVU; a = 32'd1000; b = 32'd7; in_valid = 1'b1;
      @(posedge clk); #1;
      in_valid = 1'b0;
      repeat (10) @(posedge clk);
      #1;
      check("rst_mid_busy_before", {31'd0, busy}, 32'd1);
      rst_n = 1'b0;
      @(posedge clk); #1;
      rst_n = 1'b1;
      check("rst_mid_busy", {31'd0, busy}, 32'd0);
      check("rst_mid_out_valid", {31'd0, out_valid}, 32'd0);
      check("rst_mid_in_ready", {31'd0, in_ready}, 32'd1);
      run_vec(99, '{ALU_ADD, 32'd2, 32'd3, 32'd5, 1});

      // randomized traffic with random backpressure
      for (int i = 0; i < 80; i++) begin
         op = ($urandom_range(0, 9) == 0) ? 5'($urandom_range(17, 31)) : 5'($urandom_range(0, 16));
         a = pick_operand();
         b = pick_operand();
         in_valid = 1'b1;
         out_ready = ($urandom_range(0, 3) != 0);
         #1;
         waitc = 0;
         while (!in_ready && waitc < 200) begin
            @(posedge clk); #1;
            out_ready = ($urandom_range(0, 3) != 0);
            #1;
            waitc++;
         end
         if (!in_ready) begin
            fail_now("random_accept");
            break;
         end
         @(posedge clk); #1;
         in_valid = 1'b0;
         if ($urandom_range(0, 3) == 0) begin
            @(posedge clk); #1;
         end
      end
      in_valid  = 1'b0;
      out_ready = 1'b1;
      waitc = 0;
      while (exp_q.size() != 0 && waitc < 200) begin
         @(posedge clk); #1;
         waitc++;
      end
      check("final_queue_empty", 32'(exp_q.size()), 32'd0);
      check("final_idle", {31'd0, busy}, 32'd0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
